// File: rtl/machine_counter_csrs.sv
// Machine counter CSRs: mcycle/minstret (low and high halves), mcountinhibit,
// and the optional user read-only shadows cycle/instret/cycleh/instreth.
// Reads are combinational and show the pre-update value; CSRRW/RS/RC writes
// land on the next rising edge and take priority over that counter's increment.
module machine_counter_csrs #(
  parameter int CNT_W          = 64,   // 33..64
  parameter bit USER_SHADOW_EN = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        wr_en_in,
  input  logic [11:0] csr_addr_in,
  input  logic [1:0]  csr_op_in,
  input  logic [31:0] pre_data_in,
  input  logic        instret_inc_in,
  output logic [31:0] rd_data_out,
  output logic        hit_out,
  output logic        illegal_out,
  output logic [63:0] mcycle_out,
  output logic [63:0] minstret_out
);

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_MCYCLE,
    SEL_MCYCLEH,
    SEL_MINSTRET,
    SEL_MINSTRETH,
    SEL_MCOUNTINHIBIT,
    SEL_CYCLE,
    SEL_CYCLEH,
    SEL_INSTRET,
    SEL_INSTRETH
  } csr_sel_e;

  logic [CNT_W-1:0] mcycle_q,   mcycle_d;
  logic [CNT_W-1:0] minstret_q, minstret_d;
  logic             cy_inh_q,   cy_inh_d;
  logic             ir_inh_q,   ir_inh_d;

  csr_sel_e    csr_sel;
  logic [63:0] mcycle_wide;
  logic [63:0] minstret_wide;
  logic [31:0] old_data;
  logic [31:0] wr_data;
  logic        do_write;
  logic        is_shadow;

  // Counters are presented as 64-bit values; bits above CNT_W are always zero.
  assign mcycle_wide   = 64'(mcycle_q);
  assign minstret_wide = 64'(minstret_q);
  assign mcycle_out    = mcycle_wide;
  assign minstret_out  = minstret_wide;

  // Address decode; shadows only decode when they are enabled.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave it holding its old value (which would infer a latch).
    csr_sel = SEL_NONE;
    case (csr_addr_in)
      12'hB00: csr_sel = SEL_MCYCLE;
      12'hB80: csr_sel = SEL_MCYCLEH;
      12'hB02: csr_sel = SEL_MINSTRET;
      12'hB82: csr_sel = SEL_MINSTRETH;
      12'h320: csr_sel = SEL_MCOUNTINHIBIT;
      12'hC00: if (USER_SHADOW_EN) csr_sel = SEL_CYCLE;
      12'hC80: if (USER_SHADOW_EN) csr_sel = SEL_CYCLEH;
      12'hC02: if (USER_SHADOW_EN) csr_sel = SEL_INSTRET;
      12'hC82: if (USER_SHADOW_EN) csr_sel = SEL_INSTRETH;
      default: csr_sel = SEL_NONE;
    endcase
  end

  // Read mux: current 32-bit value of the addressed CSR, also the RMW source.
  always_comb begin
    old_data = '0;
    hit_out  = 1'b1;
    case (csr_sel)
      SEL_MCYCLE,   SEL_CYCLE:    old_data = mcycle_wide[31:0];
      SEL_MCYCLEH,  SEL_CYCLEH:   old_data = mcycle_wide[63:32];
      SEL_MINSTRET, SEL_INSTRET:  old_data = minstret_wide[31:0];
      SEL_MINSTRETH, SEL_INSTRETH: old_data = minstret_wide[63:32];
      SEL_MCOUNTINHIBIT:          old_data = {29'd0, ir_inh_q, 1'b0, cy_inh_q};
      default:                    hit_out  = 1'b0;
    endcase
  end

  assign rd_data_out = old_data;

  // Write data for CSRRW / CSRRS / CSRRC.
  always_comb begin
    wr_data = old_data;
    case (csr_op_in)
      OP_RW:   wr_data = pre_data_in;
      OP_RS:   wr_data = old_data | pre_data_in;
      OP_RC:   wr_data = old_data & ~pre_data_in;
      OP_NONE: wr_data = old_data;
      default: wr_data = old_data;
    endcase
  end

  assign do_write    = wr_en_in && (csr_op_in != OP_NONE);
  assign is_shadow   = (csr_sel == SEL_CYCLE)   || (csr_sel == SEL_CYCLEH) ||
                       (csr_sel == SEL_INSTRET) || (csr_sel == SEL_INSTRETH);
  assign illegal_out = do_write && is_shadow;

  // Next-state for both counters: a write to either half replaces that half and
  // suppresses the increment; otherwise count unless inhibited (old inhibit bits).
  always_comb begin
    mcycle_d   = mcycle_q;
    minstret_d = minstret_q;

    if (do_write && csr_sel == SEL_MCYCLE)
      mcycle_d = CNT_W'({mcycle_wide[63:32], wr_data});
    else if (do_write && csr_sel == SEL_MCYCLEH)
      mcycle_d = CNT_W'({wr_data, mcycle_wide[31:0]});
    else if (!cy_inh_q)
      mcycle_d = mcycle_q + CNT_W'(1);

    if (do_write && csr_sel == SEL_MINSTRET)
      minstret_d = CNT_W'({minstret_wide[63:32], wr_data});
    else if (do_write && csr_sel == SEL_MINSTRETH)
      minstret_d = CNT_W'({wr_data, minstret_wide[31:0]});
    else if (instret_inc_in && !ir_inh_q)
      minstret_d = minstret_q + CNT_W'(1);
  end

  // Next-state for mcountinhibit: only CY (bit 0) and IR (bit 2) are storage.
  always_comb begin
    cy_inh_d = cy_inh_q;
    ir_inh_d = ir_inh_q;
    if (do_write && csr_sel == SEL_MCOUNTINHIBIT) begin
      cy_inh_d = wr_data[0];
      ir_inh_d = wr_data[2];
    end
  end

  // State register with synchronous active-low reset that overrides all updates.
  always_ff @(posedge clk_in) begin
    // NOTE: non-blocking assignments here so every flop samples the pre-edge values, independent of statement order.
    if (!rst_in) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
      cy_inh_q   <= 1'b0;
      ir_inh_q   <= 1'b0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      cy_inh_q   <= cy_inh_d;
      ir_inh_q   <= ir_inh_d;
    end
  end

endmodule
